pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Drives enable/flush for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC enable. It is the producer of enable_ID_EX/flush_ID_EX and their siblings.
- Arbitrates memory waits (ihit/dhit), load-use hazards, branch/jump flushes and halt.
- Masks re-issue of memory requests that already completed during a stall, and keeps stall/flush performance counters.

Parameters:
CNT_W, 32, width of the saturating stall and flush performance counters

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  asynchronous active-low reset
- ihit  input  1  instruction cache hit/ready this cycle
- dhit  input  1  data cache hit/ready this cycle
- dREN_EX_MEM  input  1  MEM-stage load
- dWEN_EX_MEM  input  1  MEM-stage store
- dREN_ID_EX  input  1  EX-stage load (load-use source)
- Rt_ID_EX  input  5  EX-stage load destination
- Rs_IF_ID  input  5  ID-stage source register
- Rt_IF_ID  input  5  ID-stage source register
- branch_taken_EX_MEM  input  1  branch resolved taken in MEM
- jump_IF_ID  input  1  J/JAL/JR decoded in ID
- halt_MEM_WB  input  1  halt instruction reached WB
- pc_enable  output  1  PC register load enable
- enable_IF_ID, flush_IF_ID  output  1 each  IF/ID controls
- enable_ID_EX, flush_ID_EX  output  1 each  ID/EX controls
- enable_EX_MEM, flush_EX_MEM  output  1 each  EX/MEM controls
- enable_MEM_WB, flush_MEM_WB  output  1 each  MEM/WB controls
- iREN_gated  output  1  instruction request to cache
- dREN_gated, dWEN_gated  output  1 each  data requests to cache
- halt  output  1  sticky halt to system
- stall_cycles  output  CNT_W  count of non-advancing cycles
- flush_count  output  CNT_W  count of branch/jump flush events

Behaviour:
- States: RUN, WAIT, HALTED. Registered flags if_done and mem_done. All are async cleared on nRST=0: state=RUN, flags=0, counters=0, halt=0.
- mem_op = dREN_EX_MEM | dWEN_EX_MEM.
- advance = (ihit | if_done) & (~mem_op | dhit | mem_done) & state!=HALTED.
- All enable/flush/gate outputs are combinational from state, flags and inputs.
- Request gating:
  - iREN_gated = ~if_done & state!=HALTED.
  - dREN_gated = dREN_EX_MEM & ~mem_done & state!=HALTED; dWEN_gated likewise.
- Done flags:
  - ihit while ~advance sets if_done; dhit with mem_op while ~advance sets mem_done.
  - Both clear on advance.
  - Guarantees a completed store is never written twice during a stall.
- ~advance (not HALTED): all enables 0, all flushes 0, state=WAIT, stall_cycles+1.
- advance, no hazard: all enables 1, flushes 0, state=RUN.
- Load-use hazard = dREN_ID_EX & Rt_ID_EX!=0 & (Rt_ID_EX==Rs_IF_ID | Rt_ID_EX==Rt_IF_ID).
  - With advance: pc_enable=0, enable_IF_ID=0, flush_ID_EX=1 (bubble); EX/MEM and MEM/WB enabled.
  - stall_cycles+1.
- Branch taken with advance (highest priority, overrides load-use and jump):
  - pc_enable=1.
  - flush_IF_ID=flush_ID_EX=flush_EX_MEM=1.
  - enable_MEM_WB=1.
  - flush_count+1.
- Jump with advance, no branch, no load-use: flush_IF_ID=1, all enables 1, flush_count+1.
- Jump with load-use (JR on loaded reg): load-use wins; the jump is reconsidered next cycle.
- Flushes are asserted only on advance cycles; they are never raised while stalled.
- halt_MEM_WB=1 in any state: next state HALTED, halt=1.
- HALTED: all enables 0, all gates 0, counters frozen. Exit only via nRST.
- Counters saturate at all-ones; no wrap.
- nRST asserted mid-stall: immediate return to reset values; no pending done-flag survives.

Decomposition:
- data_path_muxs_pkg gains hazard_state_t (RUN, WAIT, HALTED) and hazard_ctrl_t, a packed struct of the four enable/flush pairs plus pc_enable.
- pipeline_hazard_ctrl_if.vh is a new interface with a hazard_ctrl modport carrying all ports except CLK/nRST.
- One natural sub-module: sat_counter (CNT_W, inc, count), instantiated twice.

Test Plan:
- Reset: nRST=0 with ihit=1 -> all enables 0, halt=0, counters 0; nRST=1 with ihit=1, no hazards -> all enables 1 next cycle.
- Store stalls on icache:
  - Setup: dWEN_EX_MEM=1, dhit=1 in cycle 0, ihit=0 cycles 0-2, ihit=1 cycle 3.
  - Required: dWEN_gated=0 in cycles 1-3, advance in cycle 3, stall_cycles=3.
- Load-use:
  - Setup: dREN_ID_EX=1, Rt_ID_EX=8, Rs_IF_ID=8, ihit=1.
  - Required: pc_enable=0, enable_IF_ID=0, flush_ID_EX=1, enable_EX_MEM=1.
  - Repeat with Rt_ID_EX=0 -> no stall.
- Branch+load-use+jump same cycle: branch_taken_EX_MEM=1 -> flush IF/ID, ID/EX and EX/MEM; pc_enable=1; flush_count=1.
- Branch during dcache wait: branch_taken=1, mem_op=1, dhit=0 two cycles -> no flush until dhit cycle, then exactly one flush.
- Halt: halt_MEM_WB=1 -> halt=1 and all enables/gates 0 next cycle, held for 10 cycles; then nRST pulse clears halt.

Source files
------------

// File: rtl/data_path_muxs_pkg.sv
// Shared types for the pipeline hazard controller: FSM state, per-stage
// register control bundle and the load-use detection rule.
package data_path_muxs_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } hazard_state_t;

  typedef struct packed {
    logic pc_enable;
    logic enable_IF_ID;
    logic flush_IF_ID;
    logic enable_ID_EX;
    logic flush_ID_EX;
    logic enable_EX_MEM;
    logic flush_EX_MEM;
    logic enable_MEM_WB;
    logic flush_MEM_WB;
  } hazard_ctrl_t;

  localparam hazard_ctrl_t CTRL_HOLD = '0;

  localparam hazard_ctrl_t CTRL_RUN = '{
    pc_enable:     1'b1,
    enable_IF_ID:  1'b1,
    flush_IF_ID:   1'b0,
    enable_ID_EX:  1'b1,
    flush_ID_EX:   1'b0,
    enable_EX_MEM: 1'b1,
    flush_EX_MEM:  1'b0,
    enable_MEM_WB: 1'b1,
    flush_MEM_WB:  1'b0
  };

  // $zero never carries a real dependency, so a load into r0 is not a hazard.
  function automatic logic is_load_use(
    input logic             dren_ex,
    input logic [REG_W-1:0] rt_ex,
    input logic [REG_W-1:0] rs_id,
    input logic [REG_W-1:0] rt_id
  );
    return dren_ex && (rt_ex != '0) && ((rt_ex == rs_id) || (rt_ex == rt_id));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: arbitrates cache
// waits, load-use bubbles, branch/jump flushes and halt.
module pipeline_hazard_ctrl
  import data_path_muxs_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN_EX_MEM,
  input  logic             dWEN_EX_MEM,
  input  logic             dREN_ID_EX,
  input  logic [REG_W-1:0] Rt_ID_EX,
  input  logic [REG_W-1:0] Rs_IF_ID,
  input  logic [REG_W-1:0] Rt_IF_ID,
  input  logic             branch_taken_EX_MEM,
  input  logic             jump_IF_ID,
  input  logic             halt_MEM_WB,
  output logic             pc_enable,
  output logic             enable_IF_ID,
  output logic             flush_IF_ID,
  output logic             enable_ID_EX,
  output logic             flush_ID_EX,
  output logic             enable_EX_MEM,
  output logic             flush_EX_MEM,
  output logic             enable_MEM_WB,
  output logic             flush_MEM_WB,
  output logic             iREN_gated,
  output logic             dREN_gated,
  output logic             dWEN_gated,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output hazard_state_t    state_dbg
);

  hazard_state_t state_q, state_d;
  logic          if_done_q, if_done_d;
  logic          mem_done_q, mem_done_d;
  logic          mem_op, active, advance, load_use;
  logic          stall_inc, flush_inc;
  hazard_ctrl_t  ctrl;

  // Pipeline controls. Holding reset counts as "not advancing" so nothing
  // moves while nRST is low.
  always_comb begin
    mem_op    = dREN_EX_MEM | dWEN_EX_MEM;
    active    = nRST & (state_q != HALTED);
    advance   = (ihit | if_done_q) & (~mem_op | dhit | mem_done_q) & active;
    load_use  = is_load_use(dREN_ID_EX, Rt_ID_EX, Rs_IF_ID, Rt_IF_ID);
    ctrl      = CTRL_HOLD;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (active) begin
      if (!advance) begin
        stall_inc = 1'b1;
      end else if (branch_taken_EX_MEM) begin
        ctrl              = CTRL_RUN;
        ctrl.flush_IF_ID  = 1'b1;
        ctrl.flush_ID_EX  = 1'b1;
        ctrl.flush_EX_MEM = 1'b1;
        flush_inc         = 1'b1;
      end else if (load_use) begin
        // Freeze PC and IF/ID, inject a bubble into ID/EX; a JR on the
        // loaded register is simply re-decoded next cycle.
        ctrl              = CTRL_RUN;
        ctrl.pc_enable    = 1'b0;
        ctrl.enable_IF_ID = 1'b0;
        ctrl.flush_ID_EX  = 1'b1;
        stall_inc         = 1'b1;
      end else begin
        ctrl = CTRL_RUN;
        if (jump_IF_ID) begin
          ctrl.flush_IF_ID = 1'b1;
          flush_inc        = 1'b1;
        end
      end
    end
  end

  // A hit that lands while the pipeline is held is remembered so the request
  // is not re-issued (a store must never be written twice).
  always_comb begin
    state_d    = state_q;
    if_done_d  = if_done_q;
    mem_done_d = mem_done_q;
    if (state_q != HALTED) begin
      if (advance) begin
        if_done_d  = 1'b0;
        mem_done_d = 1'b0;
      end else begin
        if_done_d  = if_done_q | ihit;
        mem_done_d = mem_done_q | (dhit & mem_op);
      end
      if (halt_MEM_WB) begin
        state_d = HALTED;
      end else begin
        state_d = advance ? RUN : WAIT;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= RUN;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_done_q  <= if_done_d;
      mem_done_q <= mem_done_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (flush_inc),
    .count (flush_count)
  );

  assign pc_enable     = ctrl.pc_enable;
  assign enable_IF_ID  = ctrl.enable_IF_ID;
  assign flush_IF_ID   = ctrl.flush_IF_ID;
  assign enable_ID_EX  = ctrl.enable_ID_EX;
  assign flush_ID_EX   = ctrl.flush_ID_EX;
  assign enable_EX_MEM = ctrl.enable_EX_MEM;
  assign flush_EX_MEM  = ctrl.flush_EX_MEM;
  assign enable_MEM_WB = ctrl.enable_MEM_WB;
  assign flush_MEM_WB  = ctrl.flush_MEM_WB;

  assign iREN_gated = ~if_done_q & active;
  assign dREN_gated = dREN_EX_MEM & ~mem_done_q & active;
  assign dWEN_gated = dWEN_EX_MEM & ~mem_done_q & active;
  assign halt       = (state_q == HALTED);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: table vectors, hand-written multi-cycle
// corner cases and random traffic checked against a behavioural model.
module tb_pipeline_hazard_ctrl;
  import data_path_muxs_pkg::*;

  localparam int CNT_W = 32;

  typedef struct packed {
    logic       ihit;
    logic       dhit;
    logic       dren_m;
    logic       dwen_m;
    logic       dren_x;
    logic [4:0] rt_x;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic       br;
    logic       jmp;
    logic       hlt;
  } in_t;

  typedef struct {
    string       name;
    in_t         in;
    logic [12:0] exp;
    int          stall;
    int          flush;
  } row_t;

  // ---------------- clock / reset / DUT ----------------
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic ihit, dhit, dREN_EX_MEM, dWEN_EX_MEM, dREN_ID_EX;
  logic [4:0] Rt_ID_EX, Rs_IF_ID, Rt_IF_ID;
  logic branch_taken_EX_MEM, jump_IF_ID, halt_MEM_WB;
  logic pc_enable, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX;
  logic enable_EX_MEM, flush_EX_MEM, enable_MEM_WB, flush_MEM_WB;
  logic iREN_gated, dREN_gated, dWEN_gated, halt;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  hazard_state_t state_dbg;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK                 (CLK),
    .nRST                (nRST),
    .ihit                (ihit),
    .dhit                (dhit),
    .dREN_EX_MEM         (dREN_EX_MEM),
    .dWEN_EX_MEM         (dWEN_EX_MEM),
    .dREN_ID_EX          (dREN_ID_EX),
    .Rt_ID_EX            (Rt_ID_EX),
    .Rs_IF_ID            (Rs_IF_ID),
    .Rt_IF_ID            (Rt_IF_ID),
    .branch_taken_EX_MEM (branch_taken_EX_MEM),
    .jump_IF_ID          (jump_IF_ID),
    .halt_MEM_WB         (halt_MEM_WB),
    .pc_enable           (pc_enable),
    .enable_IF_ID        (enable_IF_ID),
    .flush_IF_ID         (flush_IF_ID),
    .enable_ID_EX        (enable_ID_EX),
    .flush_ID_EX         (flush_ID_EX),
    .enable_EX_MEM       (enable_EX_MEM),
    .flush_EX_MEM        (flush_EX_MEM),
    .enable_MEM_WB       (enable_MEM_WB),
    .flush_MEM_WB        (flush_MEM_WB),
    .iREN_gated          (iREN_gated),
    .dREN_gated          (dREN_gated),
    .dWEN_gated          (dWEN_gated),
    .halt                (halt),
    .stall_cycles        (stall_cycles),
    .flush_count         (flush_count),
    .state_dbg           (state_dbg)
  );

  // Bit order: [12] pc_en, [11:10] IF/ID en/fl, [9:8] ID/EX, [7:6] EX/MEM,
  // [5:4] MEM/WB, [3] iREN, [2] dREN, [1] dWEN, [0] halt.
  logic [12:0] act;
  assign act = {pc_enable, enable_IF_ID, flush_IF_ID, enable_ID_EX, flush_ID_EX,
                enable_EX_MEM, flush_EX_MEM, enable_MEM_WB, flush_MEM_WB,
                iREN_gated, dREN_gated, dWEN_gated, halt};

  function automatic logic [12:0] o(
    input logic pc, eif, fif, eid, fid, eex, fex, ewb, fwb, ir, dr, dw, h);
    return {pc, eif, fif, eid, fid, eex, fex, ewb, fwb, ir, dr, dw, h};
  endfunction

  function automatic in_t mk(
    input logic ih, dh, drm, dwm, drx, input logic [4:0] rtx, rsd, rtd,
    input logic br, jmp, hlt);
    in_t v;
    v = '{ihit: ih, dhit: dh, dren_m: drm, dwen_m: dwm, dren_x: drx,
          rt_x: rtx, rs_d: rsd, rt_d: rtd, br: br, jmp: jmp, hlt: hlt};
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit     m_halted, m_wait, m_if_done, m_mem_done;
  longint m_stall, m_flush;

  task automatic model_reset();
    m_halted = 0; m_wait = 0; m_if_done = 0; m_mem_done = 0;
    m_stall = 0; m_flush = 0;
  endtask

  // Expected outputs for this cycle; also reports whether the pipeline moves
  // and which counters tick.
  function automatic logic [12:0] model_out(input in_t v, input logic rst_ok,
                                            output bit go, output bit si, output bit fi);
    bit run, fetched, data_ok, lu;
    logic [12:0] e;
    run     = rst_ok && !m_halted;
    fetched = v.ihit || m_if_done;
    data_ok = !(v.dren_m || v.dwen_m) || v.dhit || m_mem_done;
    go      = run && fetched && data_ok;
    lu      = v.dren_x && (v.rt_x != 0) && (v.rt_x == v.rs_d || v.rt_x == v.rt_d);
    e       = '0;
    if (go) begin
      if (v.br)       e = o(1,1,1,1,1,1,1,1,0, 0,0,0,0);
      else if (lu)    e = o(0,0,0,1,1,1,0,1,0, 0,0,0,0);
      else if (v.jmp) e = o(1,1,1,1,0,1,0,1,0, 0,0,0,0);
      else            e = o(1,1,0,1,0,1,0,1,0, 0,0,0,0);
    end
    e[3] = run && !m_if_done;
    e[2] = run && v.dren_m && !m_mem_done;
    e[1] = run && v.dwen_m && !m_mem_done;
    e[0] = m_halted;
    si = run && (!go || (!v.br && lu));
    fi = go && (v.br || (v.jmp && !lu));
    return e;
  endfunction

  task automatic model_step(input in_t v, input bit go, input bit si, input bit fi);
    if (!nRST) begin
      model_reset();
    end else if (!m_halted) begin
      if (go) begin
        m_if_done = 0; m_mem_done = 0;
      end else begin
        m_if_done  = m_if_done || v.ihit;
        m_mem_done = m_mem_done || (v.dhit && (v.dren_m || v.dwen_m));
      end
      if (si && m_stall < 64'h0000_0000_FFFF_FFFF) m_stall++;
      if (fi && m_flush < 64'h0000_0000_FFFF_FFFF) m_flush++;
      if (v.hlt) m_halted = 1;
      else       m_wait = !go;
    end
  endtask

  function automatic hazard_state_t model_state();
    if (m_halted) return HALTED;
    return m_wait ? WAIT : RUN;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input in_t v);
    ihit = v.ihit; dhit = v.dhit;
    dREN_EX_MEM = v.dren_m; dWEN_EX_MEM = v.dwen_m; dREN_ID_EX = v.dren_x;
    Rt_ID_EX = v.rt_x; Rs_IF_ID = v.rs_d; Rt_IF_ID = v.rt_d;
    branch_taken_EX_MEM = v.br; jump_IF_ID = v.jmp; halt_MEM_WB = v.hlt;
  endtask

  // One clock: drive after the edge, compare mid-cycle, advance the model.
  task automatic run_cycle(input in_t v, input string tag, output logic [12:0] got);
    logic [12:0] e;
    bit go, si, fi;
    drive(v);
    @(negedge CLK);
    if (!nRST) model_reset();
    e   = model_out(v, nRST, go, si, fi);
    got = act;
    chk({tag, "_out"}, 32'(act), 32'(e));
    chk({tag, "_stall"}, stall_cycles, m_stall[31:0]);
    chk({tag, "_flush"}, flush_count, m_flush[31:0]);
    chk({tag, "_state"}, 32'(state_dbg), 32'(model_state()));
    model_step(v, go, si, fi);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    logic [12:0] g;
    nRST = 1'b0;
    run_cycle(mk(1,0,0,0,0,0,0,0,0,0,0), "rst", g);
    nRST = 1'b1;
  endtask

  // ---------------- test ----------------
  localparam logic [12:0] P_RUN = 13'b1_10_10_10_10_1_0_0_0;
  row_t rows[$];

  initial begin
    logic [12:0] g;
    in_t v;
    model_reset();
    drive(mk(1,0,0,0,0,0,0,0,0,0,0));

    rows.push_back('{"idle",      mk(1,0,0,0,0, 0, 0,0, 0,0,0), o(1,1,0,1,0,1,0,1,0,1,0,0,0), 0, 0});
    rows.push_back('{"imiss",     mk(0,0,0,0,0, 0, 0,0, 0,0,0), o(0,0,0,0,0,0,0,0,0,1,0,0,0), 1, 0});
    rows.push_back('{"lu_rs",     mk(1,0,0,0,1, 8, 8,0, 0,0,0), o(0,0,0,1,1,1,0,1,0,1,0,0,0), 1, 0});
    rows.push_back('{"lu_r0",     mk(1,0,0,0,1, 0, 0,0, 0,0,0), o(1,1,0,1,0,1,0,1,0,1,0,0,0), 0, 0});
    rows.push_back('{"lu_rt",     mk(1,0,0,0,1, 9, 3,9, 0,0,0), o(0,0,0,1,1,1,0,1,0,1,0,0,0), 1, 0});
    rows.push_back('{"br_lu_j",   mk(1,0,0,0,1, 8, 8,0, 1,1,0), o(1,1,1,1,1,1,1,1,0,1,0,0,0), 0, 1});
    rows.push_back('{"jump",      mk(1,0,0,0,0, 0, 0,0, 0,1,0), o(1,1,1,1,0,1,0,1,0,1,0,0,0), 0, 1});
    rows.push_back('{"jr_lu",     mk(1,0,0,0,1, 4, 4,0, 0,1,0), o(0,0,0,1,1,1,0,1,0,1,0,0,0), 1, 0});
    rows.push_back('{"dmiss",     mk(1,0,1,0,0, 0, 0,0, 0,0,0), o(0,0,0,0,0,0,0,0,0,1,1,0,0), 1, 0});
    rows.push_back('{"store_hit", mk(1,1,0,1,0, 0, 0,0, 0,0,0), o(1,1,0,1,0,1,0,1,0,1,0,1,0), 0, 0});
    rows.push_back('{"br_imiss",  mk(0,0,0,0,0, 0, 0,0, 1,0,0), o(0,0,0,0,0,0,0,0,0,1,0,0,0), 1, 0});
    rows.push_back('{"br_dmiss",  mk(1,0,1,0,0, 0, 0,0, 1,0,0), o(0,0,0,0,0,0,0,0,0,1,1,0,0), 1, 0});
    rows.push_back('{"halt_in",   mk(1,0,0,0,0, 0, 0,0, 0,0,1), o(1,1,0,1,0,1,0,1,0,1,0,0,0), 0, 0});

    // Reset holds everything still even with ihit high.
    @(posedge CLK); #1;
    nRST = 1'b0;
    run_cycle(mk(1,0,0,0,0,0,0,0,0,0,0), "rst_hold", g);
    chk("rst_outputs", 32'(g), 32'(0));
    nRST = 1'b1;
    run_cycle(mk(1,0,0,0,0,0,0,0,0,0,0), "rst_release", g);
    chk("rst_release_run", 32'(g), 32'(P_RUN));

    // Table vectors, each from a clean reset.
    foreach (rows[i]) begin
      do_reset();
      run_cycle(rows[i].in, rows[i].name, g);
      chk({rows[i].name, "_tbl"}, 32'(g), 32'(rows[i].exp));
      chk({rows[i].name, "_tbl_stall"}, stall_cycles, 32'(rows[i].stall));
      chk({rows[i].name, "_tbl_flush"}, flush_count, 32'(rows[i].flush));
    end

    // Store completes in cycle 0 but icache misses until cycle 3.
    do_reset();
    run_cycle(mk(0,1,0,1,0,0,0,0,0,0,0), "st_c0", g);
    chk("st_c0_dwen", 32'(g[1]), 32'(1));
    for (int c = 1; c <= 3; c++) begin
      run_cycle(mk(c == 3,0,0,1,0,0,0,0,0,0,0), $sformatf("st_c%0d", c), g);
      chk($sformatf("st_c%0d_dwen_masked", c), 32'(g[1]), 32'(0));
      chk($sformatf("st_c%0d_advance", c), 32'(g[12]), 32'(c == 3));
    end
    chk("st_stall_cycles", stall_cycles, 32'(3));

    // Branch waits behind a dcache miss: exactly one flush on the dhit cycle.
    do_reset();
    for (int c = 0; c < 2; c++) begin
      run_cycle(mk(1,0,1,0,0,0,0,0,1,0,0), "brw_wait", g);
      chk("brw_no_flush", 32'({g[10], g[8], g[6]}), 32'(0));
    end
    run_cycle(mk(0,1,1,0,0,0,0,0,1,0,0), "brw_hit", g);
    chk("brw_flush", 32'({g[12], g[10], g[8], g[6]}), 32'(4'b1111));
    run_cycle(mk(1,0,0,0,0,0,0,0,0,0,0), "brw_after", g);
    chk("brw_after_noflush", 32'({g[10], g[8], g[6]}), 32'(0));
    chk("brw_flush_count", flush_count, 32'(1));

    // Halt is sticky for 10 cycles whatever the inputs, then reset clears it.
    do_reset();
    run_cycle(mk(1,0,0,0,0,0,0,0,0,0,1), "halt_req", g);
    for (int c = 0; c < 10; c++) begin
      v = in_t'($urandom());
      v.ihit = 1'b1;
      run_cycle(v, "halted", g);
      chk("halted_frozen", 32'(g), 32'(1));
    end
    nRST = 1'b0;
    run_cycle(mk(1,0,0,0,0,0,0,0,0,0,0), "halt_rst", g);
    chk("halt_cleared", 32'(g[0]), 32'(0));
    nRST = 1'b1;
    run_cycle(mk(1,0,0,0,0,0,0,0,0,0,0), "halt_resume", g);
    chk("halt_resume_run", 32'(g), 32'(P_RUN));

    // Random traffic with small register numbers so hazards are frequent.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      v.ihit   = ($urandom_range(0, 9) < 7);
      v.dhit   = ($urandom_range(0, 1) == 1);
      v.dren_m = ($urandom_range(0, 9) < 2);
      v.dwen_m = !v.dren_m && ($urandom_range(0, 9) < 2);
      v.dren_x = ($urandom_range(0, 9) < 3);
      v.rt_x   = 5'($urandom_range(0, 3));
      v.rs_d   = 5'($urandom_range(0, 3));
      v.rt_d   = 5'($urandom_range(0, 3));
      v.br     = ($urandom_range(0, 9) == 0);
      v.jmp    = ($urandom_range(0, 9) == 0);
      v.hlt    = ($urandom_range(0, 299) == 0);
      nRST     = ($urandom_range(0, 149) != 0);
      run_cycle(v, "rand", g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
